// File: rtl/fft_butterfly_stage.sv
// Radix-2 DIT butterfly stage: SUM = A+B, DIFF = A-B on complex operands, with
// optional halving or saturation, 2-deep valid/ready pipeline, frame-last tagging and sticky overflow.
module fft_butterfly_stage #(
    parameter int unsigned DW        = 16,
    parameter int unsigned SCALE     = 1,
    parameter int unsigned FRAME_LEN = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] a_r,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_r,
    input  logic [DW-1:0] b_i,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] sum_r,
    output logic [DW-1:0] sum_i,
    output logic [DW-1:0] diff_r,
    output logic [DW-1:0] diff_i,
    output logic          out_last,
    output logic          ovf,
    input  logic          clr_ovf
);

    localparam int unsigned CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int unsigned XW = DW + 1;

    logic [CW-1:0] cnt;
    logic          last_c;
    logic          accept_c;
    logic          s2_load_c;

    logic          s1_valid;
    logic          s1_last;
    logic [DW-1:0] s1_ar, s1_ai, s1_br, s1_bi;

    logic [DW:0]   sr_c, si_c, dr_c, di_c;
    logic          clip_c;

    // Sign-extend one operand part to DW+1 bits so A+/-B cannot wrap.
    function automatic logic [XW-1:0] ext(input logic [DW-1:0] v);
        return {v[DW-1], v};
    endfunction

    // Reduce a DW+1 intermediate to DW bits; the MSB of the return is the clip flag.
    function automatic logic [DW:0] fit(input logic [XW-1:0] x);
        logic [XW-1:0] r;
        logic          clip;
        r    = '0;
        clip = 1'b0;
        if (SCALE != 0) begin
            r = XW'($signed(x + XW'(1)) >>> 1);
            return {1'b0, r[DW-1:0]};
        end
        clip = x[DW] ^ x[DW-1];
        if (!clip)
            return {1'b0, x[DW-1:0]};
        else if (x[DW])
            return {1'b1, 1'b1, {(DW-1){1'b0}}};
        else
            return {1'b1, 1'b0, {(DW-1){1'b1}}};
    endfunction

    assign s2_load_c = !out_valid || out_ready;
    assign in_ready  = !s1_valid || s2_load_c;
    assign accept_c  = in_valid && in_ready;
    assign last_c    = (cnt == CW'(FRAME_LEN - 1));

    always_comb begin
        sr_c   = fit(ext(s1_ar) + ext(s1_br));
        si_c   = fit(ext(s1_ai) + ext(s1_bi));
        dr_c   = fit(ext(s1_ar) - ext(s1_br));
        di_c   = fit(ext(s1_ai) - ext(s1_bi));
        clip_c = sr_c[DW] | si_c[DW] | dr_c[DW] | di_c[DW];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_ar     <= '0;
            s1_ai     <= '0;
            s1_br     <= '0;
            s1_bi     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            sum_r     <= '0;
            sum_i     <= '0;
            diff_r    <= '0;
            diff_i    <= '0;
            ovf       <= 1'b0;
        end else begin
            if (accept_c)
                cnt <= last_c ? '0 : cnt + CW'(1);

            // S1 refills whenever it is empty or its contents move into S2.
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_ar   <= a_r;
                    s1_ai   <= a_i;
                    s1_br   <= b_r;
                    s1_bi   <= b_i;
                    s1_last <= last_c;
                end
            end

            if (s2_load_c) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    sum_r    <= sr_c[DW-1:0];
                    sum_i    <= si_c[DW-1:0];
                    diff_r   <= dr_c[DW-1:0];
                    diff_i   <= di_c[DW-1:0];
                    out_last <= s1_last;
                end
            end

            // A new clip wins over a coincident clear.
            if (s2_load_c && s1_valid && clip_c)
                ovf <= 1'b1;
            else if (clr_ovf)
                ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fft_butterfly_stage.sv
// Scoreboard bench for fft_butterfly_stage: one saturating and one halving instance
// share the stimulus; expected results are queued at acceptance and checked at output.
module tb_fft_butterfly_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        clr_ovf = 1'b0;
    logic [15:0] a_r = '0, a_i = '0, b_r = '0, b_i = '0;

    logic        in_ready0, out_valid0, out_last0, ovf0;
    logic [15:0] sum_r0, sum_i0, diff_r0, diff_i0;
    logic        in_ready1, out_valid1, out_last1, ovf1;
    logic [15:0] sum_r1, sum_i1, diff_r1, diff_i1;

    typedef struct packed {
        logic [15:0] sr0, si0, dr0, di0;
        logic [15:0] sr1, si1, dr1, di1;
        logic        last;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   fcnt = 0;
    int   n_out = 0;

    always #5 clk = ~clk;

    fft_butterfly_stage #(.DW(16), .SCALE(0), .FRAME_LEN(2)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .a_r(a_r), .a_i(a_i), .b_r(b_r), .b_i(b_i),
        .out_valid(out_valid0), .out_ready(out_ready),
        .sum_r(sum_r0), .sum_i(sum_i0), .diff_r(diff_r0), .diff_i(diff_i0),
        .out_last(out_last0), .ovf(ovf0), .clr_ovf(clr_ovf)
    );

    fft_butterfly_stage #(.DW(16), .SCALE(1), .FRAME_LEN(2)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .a_r(a_r), .a_i(a_i), .b_r(b_r), .b_i(b_i),
        .out_valid(out_valid1), .out_ready(out_ready),
        .sum_r(sum_r1), .sum_i(sum_i1), .diff_r(diff_r1), .diff_i(diff_i1),
        .out_last(out_last1), .ovf(ovf1), .clr_ovf(clr_ovf)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference butterfly on one real/imag part.
    function automatic logic [15:0] bfly(input logic [15:0] a, input logic [15:0] b,
                                         input bit sub, input bit scl);
        int xa, xb, x;
        xa = int'($signed(a));
        xb = int'($signed(b));
        x  = sub ? xa - xb : xa + xb;
        if (scl)
            x = (x + 1) >>> 1;
        else if (x > 32767)
            x = 32767;
        else if (x < -32768)
            x = -32768;
        return 16'(x);
    endfunction

    // Monitor: readiness model, output compare, then acceptance push.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
            fcnt = 0;
        end else begin
            check_eq("in_ready_s0", 32'(in_ready0), 32'(!(q.size() == 2 && !out_ready)));
            check_eq("in_ready_s1", 32'(in_ready1), 32'(!(q.size() == 2 && !out_ready)));
            if (out_valid0 && out_ready) begin
                if (q.size() == 0) begin
                    check_eq("unexpected_out", 32'(out_valid0), 32'h0);
                end else begin
                    e = q.pop_front();
                    n_out++;
                    check_eq("sum_r_s0",  32'(sum_r0),  32'(e.sr0));
                    check_eq("sum_i_s0",  32'(sum_i0),  32'(e.si0));
                    check_eq("diff_r_s0", 32'(diff_r0), 32'(e.dr0));
                    check_eq("diff_i_s0", 32'(diff_i0), 32'(e.di0));
                    check_eq("last_s0",   32'(out_last0), 32'(e.last));
                    check_eq("valid_s1",  32'(out_valid1), 32'h1);
                    check_eq("sum_r_s1",  32'(sum_r1),  32'(e.sr1));
                    check_eq("sum_i_s1",  32'(sum_i1),  32'(e.si1));
                    check_eq("diff_r_s1", 32'(diff_r1), 32'(e.dr1));
                    check_eq("diff_i_s1", 32'(diff_i1), 32'(e.di1));
                    check_eq("last_s1",   32'(out_last1), 32'(e.last));
                end
            end
            if (in_valid && in_ready0) begin
                e.sr0  = bfly(a_r, b_r, 1'b0, 1'b0);
                e.si0  = bfly(a_i, b_i, 1'b0, 1'b0);
                e.dr0  = bfly(a_r, b_r, 1'b1, 1'b0);
                e.di0  = bfly(a_i, b_i, 1'b1, 1'b0);
                e.sr1  = bfly(a_r, b_r, 1'b0, 1'b1);
                e.si1  = bfly(a_i, b_i, 1'b0, 1'b1);
                e.dr1  = bfly(a_r, b_r, 1'b1, 1'b1);
                e.di1  = bfly(a_i, b_i, 1'b1, 1'b1);
                e.last = (fcnt == 1);
                q.push_back(e);
                fcnt = (fcnt == 1) ? 0 : fcnt + 1;
            end
        end
    end

    task automatic drive_pair(input logic [15:0] ar, input logic [15:0] ai,
                              input logic [15:0] br, input logic [15:0] bi);
        a_r = ar; a_i = ai; b_r = br; b_i = bi;
        in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready0) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        check_eq("drive_timeout", 32'(in_ready0), 32'h1);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            #1;
            if (q.size() == 0) return;
        end
        check_eq("drain_timeout", 32'(q.size()), 32'h0);
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int base;
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 32'(out_valid0), 32'h0);
        check_eq("rst_out_last",  32'(out_last0),  32'h0);
        check_eq("rst_sum_r",     32'(sum_r0),     32'h0);
        check_eq("rst_ovf",       32'(ovf0),       32'h0);
        check_eq("rst_in_ready",  32'(in_ready0),  32'h1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic sum/diff and 2-cycle latency
        drive_pair(16'h0200, 16'h0100, 16'h0100, 16'h0000);
        check_eq("lat_c1_valid", 32'(out_valid0), 32'h0);
        @(posedge clk);
        #1;
        check_eq("lat_c2_valid", 32'(out_valid0), 32'h1);
        check_eq("t1_sum_r",  32'(sum_r0),  32'h0300);
        check_eq("t1_sum_i",  32'(sum_i0),  32'h0100);
        check_eq("t1_diff_r", 32'(diff_r0), 32'h0100);
        check_eq("t1_diff_i", 32'(diff_i0), 32'h0100);
        wait_drain();
        check_eq("t1_ovf", 32'(ovf0), 32'h0);

        // Saturation, sticky ovf, clear and set-over-clear priority
        drive_pair(16'h7000, 16'h8000, 16'h7000, 16'h0001);
        @(posedge clk);
        #1;
        check_eq("t2_sum_r",  32'(sum_r0),  32'h7FFF);
        check_eq("t2_diff_r", 32'(diff_r0), 32'h0000);
        check_eq("t2_sum_i",  32'(sum_i0),  32'h8001);
        check_eq("t2_diff_i", 32'(diff_i0), 32'h8000);
        check_eq("t2_ovf_s0", 32'(ovf0), 32'h1);
        check_eq("t2_ovf_s1", 32'(ovf1), 32'h0);
        wait_drain();
        check_eq("t2_ovf_sticky", 32'(ovf0), 32'h1);
        clr_ovf = 1'b1;
        @(posedge clk);
        #1;
        clr_ovf = 1'b0;
        check_eq("t2_ovf_clr", 32'(ovf0), 32'h0);
        drive_pair(16'h7000, 16'h8000, 16'h7000, 16'h0001);
        clr_ovf = 1'b1;
        @(posedge clk);
        #1;
        clr_ovf = 1'b0;
        check_eq("t2_ovf_set_wins", 32'(ovf0), 32'h1);
        wait_drain();
        clr_ovf = 1'b1;
        @(posedge clk);
        #1;
        clr_ovf = 1'b0;

        // Halving with half-up rounding
        drive_pair(16'h0003, 16'h0000, 16'h0000, 16'h0000);
        drive_pair(16'hFFFD, 16'h0000, 16'h0000, 16'h0000);
        @(negedge clk);
        check_eq("t3_pos_sum",  32'(sum_r1),  32'h0002);
        check_eq("t3_pos_diff", 32'(diff_r1), 32'h0002);
        drive_pair(16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000);
        @(posedge clk);
        #1;
        check_eq("t3_max_sum", 32'(sum_r1), 32'h7FFF);
        wait_drain();
        check_eq("t3_ovf_s1", 32'(ovf1), 32'h0);

        // Back-pressure with random out_ready
        base = n_out;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    drive_pair(16'(i * 256), 16'(i * 16), 16'(100 - i), 16'(i * 3));
            end
            begin
                for (int j = 0; j < 40; j++) begin
                    @(posedge clk);
                    #1;
                    out_ready = (j < 4) ? 1'b0 : 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        wait_drain();
        check_eq("t4_count", 32'(n_out - base), 32'd6);

        // Frame tagging and counter restart on reset
        reset_pulse();
        base = n_out;
        for (int i = 0; i < 5; i++)
            drive_pair(16'(i + 1), 16'h0, 16'h0, 16'h0);
        wait_drain();
        check_eq("t5_count", 32'(n_out - base), 32'd5);
        for (int i = 0; i < 3; i++)
            drive_pair(16'(i + 9), 16'h0, 16'h0, 16'h0);
        reset_pulse();
        drive_pair(16'h0040, 16'h0, 16'h0, 16'h0);
        @(posedge clk);
        #1;
        check_eq("t5_last_after_rst", 32'(out_last0), 32'h0);
        wait_drain();

        // Async reset while both stages are full and stalled
        out_ready = 1'b0;
        drive_pair(16'h7000, 16'h0, 16'h7000, 16'h0);
        drive_pair(16'h7000, 16'h0, 16'h7000, 16'h0);
        check_eq("t6_stall_ready", 32'(in_ready0), 32'h0);
        check_eq("t6_stall_valid", 32'(out_valid0), 32'h1);
        check_eq("t6_ovf_pre", 32'(ovf0), 32'h1);
        #1;
        rst = 1'b1;
        #1;
        check_eq("t6_rst_valid", 32'(out_valid0), 32'h0);
        check_eq("t6_rst_sum_r", 32'(sum_r0), 32'h0);
        check_eq("t6_rst_ovf",   32'(ovf0), 32'h0);
        check_eq("t6_rst_last",  32'(out_last0), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("t6_post_ready", 32'(in_ready0), 32'h1);
        check_eq("t6_post_valid", 32'(out_valid0), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
